// File: rtl/quadtree_ram_mlane.sv
// Multi-lane RAM read pipeline: one write port, NUM_LANES read copies, write-first forwarding,
// a post-reset clear sweep, and a fixed latency of 1 + OUT_REG_ENABLE cycles with no backpressure.
module quadtree_ram_mlane #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 6,
  parameter int                    BYPASS_WIDTH   = 1,
  parameter int                    NUM_LANES      = 2,
  parameter int                    OUT_REG_ENABLE = 0,
  parameter int                    INIT_ENABLE    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [DATA_WIDTH-1:0]             wr_data_i,
  input  logic [ADDR_WIDTH-1:0]             wr_addr_i,
  input  logic                              wr_enable_i,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   in_read_addr_i,
  input  logic [NUM_LANES*BYPASS_WIDTH-1:0] in_bypass_i,
  input  logic [NUM_LANES-1:0]              in_valid_i,
  output logic                              in_ready_o,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   out_read_data_o,
  output logic [NUM_LANES*BYPASS_WIDTH-1:0] out_bypass_o,
  output logic [NUM_LANES-1:0]              out_valid_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;
  logic                    run;

  assign run        = (state_q == ST_RUN);
  assign in_ready_o = ready_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
      ready_q <= (INIT_ENABLE == 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // The sweep owns the write port until the last address is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = wr_addr_i;
    mem_wd  = wr_data_i;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = INIT_VALUE;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
      end
      default: mem_we = wr_enable_i;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    acc;
    logic                    hit;
    logic                    v1_q;
    logic [BYPASS_WIDTH-1:0] bp1_q;
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    fwd_q;
    logic [DATA_WIDTH-1:0]   fwd_dat_q;
    logic [DATA_WIDTH-1:0]   d1;

    assign rd_addr = in_read_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign acc     = run && in_valid_i[k];
    assign hit     = acc && mem_we && (mem_wa == rd_addr);

    always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    // The primitive returns pre-write data, so a same-cycle write is captured alongside it.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v1_q      <= 1'b0;
        bp1_q     <= '0;
        ram_q     <= '0;
        fwd_q     <= 1'b0;
        fwd_dat_q <= '0;
      end else begin
        v1_q      <= acc;
        bp1_q     <= in_bypass_i[k*BYPASS_WIDTH +: BYPASS_WIDTH];
        ram_q     <= mem_q[rd_addr];
        fwd_q     <= hit;
        fwd_dat_q <= wr_data_i;
      end
    end

    assign d1 = fwd_q ? fwd_dat_q : ram_q;

    if (OUT_REG_ENABLE != 0) begin : g_oreg
      logic                    v2_q;
      logic [BYPASS_WIDTH-1:0] bp2_q;
      logic [DATA_WIDTH-1:0]   d2_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v2_q  <= 1'b0;
          bp2_q <= '0;
          d2_q  <= '0;
        end else begin
          v2_q  <= v1_q;
          bp2_q <= bp1_q;
          d2_q  <= d1;
        end
      end

      assign out_valid_o[k]                                  = v2_q;
      assign out_bypass_o[k*BYPASS_WIDTH +: BYPASS_WIDTH]    = bp2_q;
      assign out_read_data_o[k*DATA_WIDTH +: DATA_WIDTH]     = d2_q;
    end else begin : g_noreg
      assign out_valid_o[k]                                  = v1_q;
      assign out_bypass_o[k*BYPASS_WIDTH +: BYPASS_WIDTH]    = bp1_q;
      assign out_read_data_o[k*DATA_WIDTH +: DATA_WIDTH]     = d1;
    end
  end

endmodule

// File: tb/tb_quadtree_ram_mlane.sv
// Directed bench: two instances (no output register / output register) share one stimulus stream.
module tb_quadtree_ram_mlane;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_data;
  logic [3:0]  wr_addr;
  logic        wr_en;
  logic [7:0]  raddr;
  logic [7:0]  bp;
  logic [1:0]  vld;

  logic        rdy0, rdy1;
  logic [15:0] dat0, dat1;
  logic [7:0]  bpo0, bpo1;
  logic [1:0]  vo0, vo1;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  quadtree_ram_mlane #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .BYPASS_WIDTH(4), .NUM_LANES(2),
    .OUT_REG_ENABLE(0), .INIT_ENABLE(1), .INIT_VALUE(8'hA5)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_addr_i(wr_addr),
    .wr_enable_i(wr_en), .in_read_addr_i(raddr), .in_bypass_i(bp), .in_valid_i(vld),
    .in_ready_o(rdy0), .out_read_data_o(dat0), .out_bypass_o(bpo0), .out_valid_o(vo0)
  );

  quadtree_ram_mlane #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .BYPASS_WIDTH(4), .NUM_LANES(2),
    .OUT_REG_ENABLE(1), .INIT_ENABLE(1), .INIT_VALUE(8'hA5)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_addr_i(wr_addr),
    .wr_enable_i(wr_en), .in_read_addr_i(raddr), .in_bypass_i(bp), .in_valid_i(vld),
    .in_ready_o(rdy1), .out_read_data_o(dat1), .out_bypass_o(bpo1), .out_valid_o(vo1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_data = '0; wr_addr = '0; wr_en = 1'b0;
    raddr = '0; bp = '0; vld = '0;
    #12;
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    chk("rst_valid0", 32'(vo0), 32'd0);
    chk("rst_valid1", 32'(vo1), 32'd0);
    chk("rst_data0", 32'(dat0), 32'd0);
    chk("rst_data1", 32'(dat1), 32'd0);
    chk("rst_bp0", 32'(bpo0), 32'd0);
    chk("rst_bp1", 32'(bpo1), 32'd0);

    // Reset in the middle of the sweep
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (7) tick();
    chk("mid_sweep_ready", 32'(rdy0), 32'd0);
    rst = 1'b1;
    #1;
    chk("rerst_ready0", 32'(rdy0), 32'd0);
    chk("rerst_ready1", 32'(rdy1), 32'd0);
    chk("rerst_valid0", 32'(vo0), 32'd0);
    chk("rerst_valid1", 32'(vo1), 32'd0);
    tick();
    rst = 1'b0;

    // Requests and writes during the sweep are ignored
    vld = 2'b11; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11;
    raddr = {4'd2, 4'd2}; bp = 8'h33;
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk("init_valid0", 32'(vo0), 32'd0);
      chk("init_valid1", 32'(vo1), 32'd0);
      chk("init_ready", 32'(rdy0), (e == 16) ? 32'd1 : 32'd0);
    end
    vld = 2'b00; wr_en = 1'b0;

    // Sweep readback, streaming through both latencies
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        raddr = {4'(15 - i), 4'(i)};
        bp    = {4'(i), 4'(i)};
        vld   = 2'b11;
      end else begin
        vld = 2'b00;
      end
      tick();
      if (i < 16) begin
        chk("sweep_valid0", 32'(vo0), 32'h3);
        chk("sweep_data0", 32'(dat0), 32'hA5A5);
        chk("sweep_bp0", 32'(bpo0), 32'({4'(i), 4'(i)}));
      end else begin
        chk("sweep_end_valid0", 32'(vo0), 32'd0);
      end
      if (i >= 1) begin
        chk("stream_valid1", 32'(vo1), 32'h3);
        chk("stream_data1", 32'(dat1), 32'hA5A5);
        chk("stream_bp1", 32'(bpo1), 32'({4'(i - 1), 4'(i - 1)}));
      end else begin
        chk("stream_lat_valid1", 32'(vo1), 32'd0);
      end
    end
    tick();
    chk("stream_end_valid1", 32'(vo1), 32'd0);

    // Same-cycle write forwarding
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h3C;
    raddr = {4'd4, 4'd3}; bp = 8'h21; vld = 2'b11;
    tick();
    chk("fwd_valid0", 32'(vo0), 32'h3);
    chk("fwd_data0", 32'(dat0), 32'hA53C);
    chk("fwd_bp0", 32'(bpo0), 32'h21);
    chk("fwd_lat_valid1", 32'(vo1), 32'd0);
    wr_en = 1'b0; vld = 2'b00;
    tick();
    chk("fwd_valid1", 32'(vo1), 32'h3);
    chk("fwd_data1", 32'(dat1), 32'hA53C);
    chk("fwd_idle_valid0", 32'(vo0), 32'd0);

    // A write one cycle after the read must not leak into it
    raddr = {4'd5, 4'd5}; bp = 8'h65; vld = 2'b11;
    tick();
    chk("late_wr_data0", 32'(dat0), 32'hA5A5);
    chk("late_wr_valid0", 32'(vo0), 32'h3);
    vld = 2'b00; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h77;
    tick();
    chk("late_wr_data1", 32'(dat1), 32'hA5A5);
    chk("late_wr_valid1", 32'(vo1), 32'h3);
    chk("late_wr_idle0", 32'(vo0), 32'd0);
    wr_en = 1'b0; vld = 2'b11; bp = 8'h9A;
    tick();
    chk("after_wr_data0", 32'(dat0), 32'h7777);
    chk("after_wr_bp0", 32'(bpo0), 32'h9A);
    vld = 2'b00;
    tick();
    chk("after_wr_data1", 32'(dat1), 32'h7777);
    chk("after_wr_valid1", 32'(vo1), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/quadtree_ram_mlane.md
# quadtree_ram_mlane

Multi-lane, latency-controlled RAM read pipeline with same-cycle write forwarding and a power-up clear sweep. One write port feeds `NUM_LANES` independent read lanes; each lane carries a bypass word and a valid alongside its read so downstream quadtree stages receive data and context aligned. It is the general form of the single-lane RAM-with-delay block. It adds lane count, write-first read semantics, and self-initialisation after reset.

## Interface
Parameters:
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 6: RAM depth is `2**ADDR_WIDTH`.
- `BYPASS_WIDTH`, 1: per-lane sideband width.
- `NUM_LANES`, 2: read lanes, 1..8. Each lane has its own RAM copy, and all copies receive the same writes.
- `OUT_REG_ENABLE`, 0: 1 adds an output register stage.
- `INIT_ENABLE`, 1: 1 runs the clear sweep after reset.
- `INIT_VALUE`, 0: word written to every address by the sweep.

Ports. One clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `wr_data_i`  in  `DATA_WIDTH`  write data.
- `wr_addr_i`  in  `ADDR_WIDTH`  write address.
- `wr_enable_i`  in  1  write strobe.
- `in_read_addr_i`  in  `NUM_LANES*ADDR_WIDTH`  lane k occupies bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `in_bypass_i`  in  `NUM_LANES*BYPASS_WIDTH`  per-lane sideband.
- `in_valid_i`  in  `NUM_LANES`  per-lane read request.
- `in_ready_o`  out  1  high once the block is in RUN.
- `out_read_data_o`  out  `NUM_LANES*DATA_WIDTH`  per-lane read data.
- `out_bypass_o`  out  `NUM_LANES*BYPASS_WIDTH`  per-lane sideband, delayed.
- `out_valid_o`  out  `NUM_LANES`  per-lane valid.

## Operation
State machine: `INIT` and `RUN`.
- Reset enters `INIT` if `INIT_ENABLE=1`, otherwise `RUN`.
- `INIT`:
  - An `ADDR_WIDTH`-bit counter starts at 0 and writes `INIT_VALUE` to address `cnt` in every RAM copy, one address per cycle.
  - When `cnt == 2**ADDR_WIDTH-1` is written, the next state is `RUN`.
  - `wr_enable_i` is ignored.
  - `in_valid_i` is ignored: requests are dropped and no output results.
- `RUN`:
  - The write port drives all RAM copies.
  - A lane read is accepted when `in_valid_i[k]` is high; `in_ready_o` is high.
- RAM primitive:
  - Registered read address; data appears 1 cycle later.
  - A write and a read to the same address in the same cycle returns the old data from the primitive.
- Read semantics are write-first: a read accepted at cycle t returns the value of `mem[A]` after all writes at cycles ≤ t.
- Forwarding:
  - At acceptance, each lane compares `wr_enable_i && wr_addr_i == addr_k`.
  - On a match, the lane captures `wr_data_i` and a forward flag into its stage-1 register.
  - At stage 1, the output mux selects the forwarded data when the flag is set, otherwise the RAM output.
- Writes at cycles > t never affect a read accepted at t, including the write landing while the read is in the `OUT_REG_ENABLE` stage.
- Lanes are fully independent. Any subset may be valid in a cycle, and all lanes may read the same address.
- Bypass and valid travel through the same stages as the data. Lane order and bypass association are preserved.
- Output data and bypass are don't-care when the matching valid is 0. Their registers still update; the bench checks them only when valid.

## Timing
- Latency from `in_valid_i` to `out_valid_o` is `1 + OUT_REG_ENABLE` cycles, fixed.
- Throughput is one read per lane per cycle. There is no backpressure and no stall.
- Sweep duration: `in_ready_o` rises on the `2**ADDR_WIDTH`-th rising edge after `rst_i` deasserts. A request is first accepted on the following edge.
- Reset values:
  - `out_valid_o` = 0, `out_read_data_o` = 0, `out_bypass_o` = 0.
  - `in_ready_o` = `!INIT_ENABLE`.
  - Sweep counter = 0; all forward flags = 0.
- Reset mid-operation:
  - All in-flight valids are discarded and no late outputs appear.
  - The sweep restarts from address 0.
  - RAM contents are not cleared by the reset itself, only by the sweep.
- `in_ready_o` is a registered function of state; it has no combinational path from any input.

## Test plan
Configuration unless stated: `DATA_WIDTH=8`, `ADDR_WIDTH=4`, `BYPASS_WIDTH=4`, `NUM_LANES=2`, `INIT_VALUE=8'hA5`, `OUT_REG_ENABLE=0`.

1. **Clear sweep.** Release reset, then read addresses 0..15 on both lanes -> `in_ready_o` rises at edge 16 after release; all 32 results are 0xA5 with the correct bypass.
2. **Same-cycle forward.** At cycle t: write addr 3 = 0x3C; lane0 reads addr 3, lane1 reads addr 4 -> at t+1 lane0 = 0x3C, lane1 = 0xA5.
3. **No forward from later writes.** Read addr 5 at t; write addr 5 = 0x77 at t+1 -> result 0xA5. A read at t+2 -> 0x77. Repeat with `OUT_REG_ENABLE=1` -> same values, latency 2.
4. **Streaming.** `OUT_REG_ENABLE=1`, back-to-back reads for 16 cycles, bypass = index -> `out_valid_o` continuous from cycle 2; bypass sequence 0..15 in order on both lanes.
5. **Reset mid-sweep.** Assert `rst_i` at sweep count 7 -> `in_ready_o` and `out_valid_o` are 0 immediately; ready rises 16 edges after the second release.
6. **Inputs during INIT.** Drive `in_valid_i=2'b11` and `wr_enable_i=1` (addr 2 = 0x11) throughout INIT -> no `out_valid_o`; a later read of addr 2 returns 0xA5.
